wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Write-back stage and register file: the consumer end of the MEM->WB pipeline register.
//  - Selects the write-back value: data-memory read data or ALU result.
//  - Commits the value into a 32-entry register file.
//  - Serves the two ID-stage read ports, with same-cycle write-through bypass.
//  - Counts committed register writes, for retirement and debug visibility.
// PARAMETERS
//  DATA_W   32  register / datapath width
//  ADDR_W   5   register address width; depth = 2**ADDR_W
//  CNT_W    32  width of the write-commit counter
// PORTS
//  CLK                 in   1       clock; all state updates on posedge
//  RST                 in   1       synchronous reset, active-high
//  in_DM_Read_data     in   DATA_W  MEM/WB data-memory read data
//  in_ALU_result       in   DATA_W  MEM/WB ALU result
//  in_Reg_Write_addr   in   ADDR_W  MEM/WB destination register
//  in_MemToReg         in   1       1 = write DM data, 0 = write ALU result
//  in_RegWrite         in   1       write enable from MEM/WB
//  in_Read_addr1       in   ADDR_W  ID read port 1 address (rs)
//  in_Read_addr2       in   ADDR_W  ID read port 2 address (rt)
//  out_Read_data1      out  DATA_W  read port 1 data (combinational)
//  out_Read_data2      out  DATA_W  read port 2 data (combinational)
//  out_WB_data         out  DATA_W  selected write-back value (combinational)
//  out_Write_count     out  CNT_W   number of committed writes, registered
// BEHAVIOUR
//  - Write-back mux: out_WB_data = in_MemToReg ? in_DM_Read_data : in_ALU_result.
//    Pure combinational; valid whatever the state of in_RegWrite.
//  - Commit condition: in_RegWrite && in_Reg_Write_addr != 0 && !RST.
//  - Commit action, at posedge CLK: regs[in_Reg_Write_addr] <= out_WB_data;
//    out_Write_count <= out_Write_count + 1.
//  - Register 0: hardwired to zero. A write to it is discarded and does not increment the count.
//  - Read ports: asynchronous. out_Read_dataN = 0 when in_Read_addrN == 0.
//  - Bypass: if the commit condition holds and in_Read_addrN == in_Reg_Write_addr,
//    out_Read_dataN = out_WB_data in the same cycle, before the edge.
//    Both ports may bypass simultaneously.
//    Otherwise out_Read_dataN = regs[in_Read_addrN].
//  - Latency: write visible on the read ports in the same cycle via bypass,
//    and from the register array from the cycle after the edge.
//  - Reset, sampled at posedge CLK while RST = 1:
//    - all regs, out_Write_count <= 0.
//    - RST overrides a concurrent write: that write is lost and the count stays 0.
//    - While RST is high the bypass is disabled; read ports show array contents (0 after the first reset edge).
//  - Reset mid-operation: any cycle with RST = 1 discards pending state. No partial commit.
//  - Counter: wraps modulo 2**CNT_W; no saturation and no flag.
//  - Inputs marked X while in_RegWrite = 0 must not corrupt any state.
//  - Write and read of different registers in the same cycle are independent.
// TESTING
//  1. RST = 1 for 2 cycles, then 0
//     -> reads of r1..r31 return 0; out_Write_count = 0.
//  2. RegWrite = 1, addr = 5, MemToReg = 0, ALU = 32'hDEAD_BEEF; same cycle read1 = 5
//     -> out_Read_data1 = DEADBEEF (bypass); next cycle still DEADBEEF; count = 1.
//  3. RegWrite = 1, addr = 0, DM = 32'h1234_5678, MemToReg = 1; read1 = 0
//     -> out_Read_data1 = 0 before and after the edge; count unchanged.
//  4. MemToReg = 1, DM = 32'hCAFE_0001, ALU = 32'h0000_0002, addr = 9; read1 = read2 = 9
//     -> both ports = CAFE0001 same cycle; r9 = CAFE0001 after the edge.
//  5. RegWrite = 1, addr = 7, ALU = 32'h55 with RST = 1 at the same edge
//     -> r7 = 0 after the edge; count = 0.
//  6. Preload count to 2**CNT_W-1 (force or CNT_W = 4 build), one valid write
//     -> count wraps to 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back select, 32-entry register file and commit counter.
// Reads are asynchronous with same-cycle write-through bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_DM_Read_data,
  input  logic [DATA_W-1:0] in_ALU_result,
  input  logic [ADDR_W-1:0] in_Reg_Write_addr,
  input  logic              in_MemToReg,
  input  logic              in_RegWrite,
  input  logic [ADDR_W-1:0] in_Read_addr1,
  input  logic [ADDR_W-1:0] in_Read_addr2,
  output logic [DATA_W-1:0] out_Read_data1,
  output logic [DATA_W-1:0] out_Read_data2,
  output logic [DATA_W-1:0] out_WB_data,
  output logic [CNT_W-1:0]  out_Write_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  assign out_WB_data = in_MemToReg ? in_DM_Read_data
                                   : in_ALU_result;

  // r0 writes and writes under reset never commit
  assign commit = in_RegWrite
               && (in_Reg_Write_addr != '0)
               && !RST;

  // read port 1: zero reg, bypass, then array
  always_comb begin
    out_Read_data1 = regs[in_Read_addr1];
    if (in_Read_addr1 == '0)
      out_Read_data1 = '0;
    else if (commit && in_Read_addr1 == in_Reg_Write_addr)
      out_Read_data1 = out_WB_data;
  end

  // read port 2: zero reg, bypass, then array
  always_comb begin
    out_Read_data2 = regs[in_Read_addr2];
    if (in_Read_addr2 == '0)
      out_Read_data2 = '0;
    else if (commit && in_Read_addr2 == in_Reg_Write_addr)
      out_Read_data2 = out_WB_data;
  end

  // register array commit and retirement counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      out_Write_count <= '0;
    end else if (commit) begin
      regs[in_Reg_Write_addr] <= out_WB_data;
      out_Write_count <= out_Write_count + CNT_W'(1);
    end
  end

endmodule
